// File: rtl/vector_aes_dec_unit_pkg.sv
// Shared AES inverse-cipher definitions: op encoding, FSM states, inverse S-box and GF(2^8) helpers.
package aes_pkg;

    typedef enum logic [1:0] {
        OP_INV_SHIFTROWS  = 2'b00,
        OP_INV_SUBBYTES   = 2'b01,
        OP_INV_MIXCOLUMNS = 2'b10,
        OP_INV_ROUND      = 2'b11
    } vaes_dec_op;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SUB  = 2'd1;
    localparam logic [1:0] ST_MIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Element 0 is the leftmost byte, so INV_SBOX[x] is the inverse substitution of x.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = gf_xtime(p);
        end
        return acc;
    endfunction

    // Column word is {row0, row1, row2, row3}, row0 in the most significant byte.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        s0 = c[31:24];
        s1 = c[23:16];
        s2 = c[15:8];
        s3 = c[7:0];
        return {gf_mul(s0, 8'h0e) ^ gf_mul(s1, 8'h0b) ^ gf_mul(s2, 8'h0d) ^ gf_mul(s3, 8'h09),
                gf_mul(s0, 8'h09) ^ gf_mul(s1, 8'h0e) ^ gf_mul(s2, 8'h0b) ^ gf_mul(s3, 8'h0d),
                gf_mul(s0, 8'h0d) ^ gf_mul(s1, 8'h09) ^ gf_mul(s2, 8'h0e) ^ gf_mul(s3, 8'h0b),
                gf_mul(s0, 8'h0b) ^ gf_mul(s1, 8'h0d) ^ gf_mul(s2, 8'h09) ^ gf_mul(s3, 8'h0e)};
    endfunction

    // Row r is rotated right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box lookup, one byte per instance.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] addr,
    output logic [7:0] data
);

    assign data = INV_SBOX[addr];

endmodule

// File: rtl/vector_aes_dec_unit.sv
// Multicycle AES-128 inverse-cipher unit (InvShiftRows / InvSubBytes / InvMixColumns / fused round).
// Define VAES_DEC_FAST_SBOX_EN for 16 parallel inverse S-boxes (single-cycle SUB); default shares 4.
module vector_aes_dec_unit
    import aes_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] state_in,
    input  logic [WIDTH-1:0] rkey_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    logic [1:0]       state;
    logic [1:0]       col;
    logic [1:0]       col_idx;
    vaes_dec_op       op_q;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] rkey;
    logic [WIDTH-1:0] held;

    logic [3:0][31:0] cols;
    logic [WIDTH-1:0] sub_word;
    logic             sub_last;
    logic [WIDTH-1:0] sub_next;
    logic [3:0][31:0] mix_cols;

    assign cols    = work;
    assign col_idx = 2'd3 - col;

`ifdef VAES_DEC_FAST_SBOX_EN
    for (genvar k = 0; k < 16; k++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .addr (work[127-8*k -: 8]),
            .data (sub_word[127-8*k -: 8])
        );
    end
    assign sub_last = 1'b1;
`else
    logic [31:0]      sub_col;
    logic [3:0][31:0] sub_cols;

    for (genvar k = 0; k < 4; k++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .addr (cols[col_idx][31-8*k -: 8]),
            .data (sub_col[31-8*k -: 8])
        );
    end

    always_comb begin
        sub_cols          = cols;
        sub_cols[col_idx] = sub_col;
    end

    assign sub_word = sub_cols;
    assign sub_last = (col == 2'd3);
`endif

    // The round key is folded into the final substitution write of a fused round.
    assign sub_next = sub_word ^ (((op_q == OP_INV_ROUND) && sub_last) ? rkey : '0);

    always_comb begin
        mix_cols          = cols;
        mix_cols[col_idx] = inv_mix_column(cols[col_idx]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            col   <= 2'd0;
            op_q  <= OP_INV_SHIFTROWS;
            work  <= '0;
            rkey  <= '0;
            held  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q <= vaes_dec_op'(op);
                        rkey <= rkey_in;
                        col  <= 2'd0;
                        if ((op == OP_INV_SHIFTROWS) || (op == OP_INV_ROUND))
                            work <= inv_shift_rows(state_in);
                        else
                            work <= state_in;
                        if (op == OP_INV_SHIFTROWS)
                            state <= ST_DONE;
                        else if (op == OP_INV_MIXCOLUMNS)
                            state <= ST_MIX;
                        else
                            state <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    work <= sub_next;
                    col  <= col + 2'd1;
                    if (sub_last) begin
                        col   <= 2'd0;
                        state <= (op_q == OP_INV_ROUND) ? ST_MIX : ST_DONE;
                    end
                end
                ST_MIX: begin
                    work <= mix_cols;
                    col  <= col + 2'd1;
                    if (col == 2'd3) begin
                        col   <= 2'd0;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    held <= work;
                    if (out_ready) state <= ST_IDLE;
                end
            endcase
        end
    end

    // Result keeps the last completed value after the handshake.
    assign result    = (state == ST_DONE) ? work : held;
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_vector_aes_dec_unit.sv
// Directed self-checking bench for vector_aes_dec_unit; honours VAES_DEC_FAST_SBOX_EN for latencies.
module tb_vector_aes_dec_unit;

`ifdef VAES_DEC_FAST_SBOX_EN
    localparam int LAT_SUB   = 2;
    localparam int LAT_ROUND = 6;
`else
    localparam int LAT_SUB   = 5;
    localparam int LAT_ROUND = 9;
`endif
    localparam int LAT_SR  = 1;
    localparam int LAT_MIX = 5;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [127:0] state_in;
    logic [127:0] rkey_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] result;

    int n_checks;
    int n_fails;

    vector_aes_dec_unit #(.WIDTH(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .state_in  (state_in),
        .rkey_in   (rkey_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request and returns the accept-to-out_valid latency and the result seen then.
    task automatic run_op(input logic [1:0] o, input logic [127:0] s, input logic [127:0] k,
                          output int lat, output logic [127:0] res);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1;
        op       = o;
        state_in = s;
        rkey_in  = k;
        @(posedge clk); #1;
        in_valid = 1'b0;
        state_in = '0;
        rkey_in  = '0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 2'b00;
        state_in  = '0;
        rkey_in   = '0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL reset_in_ready_during: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (result !== 128'h0) begin
            n_fails++;
            $display("[TB] FAIL reset_result: got %h expected 0", result);
        end
    endtask

    task automatic test_inv_mixcolumns();
        int           lat;
        logic [127:0] res;
        run_op(2'b10, {32'h8e4da1bc, 96'h0}, '0, lat, res);
        n_checks++;
        if (res !== {32'hdb135345, 96'h0}) begin
            n_fails++;
            $display("[TB] FAIL mix_col0: got %h expected %h", res, {32'hdb135345, 96'h0});
        end
        n_checks++;
        if (lat !== LAT_MIX) begin
            n_fails++;
            $display("[TB] FAIL mix_latency: got %0d expected %0d", lat, LAT_MIX);
        end
        run_op(2'b10, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, '0, lat, res);
        n_checks++;
        if (res !== 128'hdb135345_f20a225c_d4d4d4d5_2d26314c) begin
            n_fails++;
            $display("[TB] FAIL mix_all_cols: got %h expected %h", res,
                     128'hdb135345_f20a225c_d4d4d4d5_2d26314c);
        end
    endtask

    task automatic test_inv_subbytes();
        int           lat;
        logic [127:0] res;
        run_op(2'b01, {16{8'h63}}, '0, lat, res);
        n_checks++;
        if (res !== 128'h0) begin
            n_fails++;
            $display("[TB] FAIL sub_63: got %h expected 0", res);
        end
        n_checks++;
        if (lat !== LAT_SUB) begin
            n_fails++;
            $display("[TB] FAIL sub_latency: got %0d expected %0d", lat, LAT_SUB);
        end
        run_op(2'b01, {16{8'h7c}}, '0, lat, res);
        n_checks++;
        if (res !== {16{8'h01}}) begin
            n_fails++;
            $display("[TB] FAIL sub_7c: got %h expected %h", res, {16{8'h01}});
        end
        run_op(2'b01, 128'h000102030405060708090a0b0c0d0e0f, '0, lat, res);
        n_checks++;
        if (res !== 128'h52096ad53036a538bf40a39e81f3d7fb) begin
            n_fails++;
            $display("[TB] FAIL sub_ramp: got %h expected %h", res,
                     128'h52096ad53036a538bf40a39e81f3d7fb);
        end
    endtask

    task automatic test_inv_shiftrows();
        int           lat;
        logic [127:0] res;
        run_op(2'b00, 128'h000102030405060708090a0b0c0d0e0f, '0, lat, res);
        n_checks++;
        if (res !== 128'h000d0a0704010e0b0805020f0c090603) begin
            n_fails++;
            $display("[TB] FAIL shiftrows: got %h expected %h", res,
                     128'h000d0a0704010e0b0805020f0c090603);
        end
        n_checks++;
        if (lat !== LAT_SR) begin
            n_fails++;
            $display("[TB] FAIL shiftrows_latency: got %0d expected %0d", lat, LAT_SR);
        end
    endtask

    task automatic test_inv_round();
        int           lat;
        logic [127:0] res;
        run_op(2'b11, {16{8'h63}}, '0, lat, res);
        n_checks++;
        if (res !== 128'h0) begin
            n_fails++;
            $display("[TB] FAIL round_key0: got %h expected 0", res);
        end
        n_checks++;
        if (lat !== LAT_ROUND) begin
            n_fails++;
            $display("[TB] FAIL round_latency: got %0d expected %0d", lat, LAT_ROUND);
        end
        run_op(2'b11, {16{8'h63}}, {16{8'h01}}, lat, res);
        n_checks++;
        if (res !== {16{8'h01}}) begin
            n_fails++;
            $display("[TB] FAIL round_key01: got %h expected %h", res, {16{8'h01}});
        end
        // Substitution yields zero, so the key alone feeds InvMixColumns on every column.
        run_op(2'b11, {16{8'h63}}, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, lat, res);
        n_checks++;
        if (res !== 128'hdb135345_f20a225c_d4d4d4d5_2d26314c) begin
            n_fails++;
            $display("[TB] FAIL round_keymix: got %h expected %h", res,
                     128'hdb135345_f20a225c_d4d4d4d5_2d26314c);
        end
    endtask

    task automatic test_backpressure();
        int           lat;
        logic [127:0] res;
        out_ready = 1'b0;
        run_op(2'b00, 128'h000102030405060708090a0b0c0d0e0f, '0, lat, res);
        in_valid = 1'b1;
        op       = 2'b01;
        state_in = {16{8'h7c}};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ((out_valid !== 1'b1) || (in_ready !== 1'b0) ||
                (result !== 128'h000d0a0704010e0b0805020f0c090603)) begin
                n_fails++;
                $display("[TB] FAIL stall_cycle%0d: got valid=%b ready=%b result=%h expected 1 0 %h",
                         i, out_valid, in_ready, result, 128'h000d0a0704010e0b0805020f0c090603);
            end
        end
        in_valid  = 1'b0;
        state_in  = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ((in_ready !== 1'b1) || (out_valid !== 1'b0)) begin
            n_fails++;
            $display("[TB] FAIL stall_release: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if ((in_ready !== 1'b1) || (out_valid !== 1'b0)) begin
            n_fails++;
            $display("[TB] FAIL stall_dropped: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int           lat;
        logic [127:0] res;
        run_op(2'b00, 128'h000102030405060708090a0b0c0d0e0f, '0, lat, res);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL b2b_ready: got %b expected 1", in_ready);
        end
        run_op(2'b01, {16{8'h7c}}, '0, lat, res);
        n_checks++;
        if ((res !== {16{8'h01}}) || (lat !== LAT_SUB)) begin
            n_fails++;
            $display("[TB] FAIL b2b_second: got %h lat %0d expected %h lat %0d",
                     res, lat, {16{8'h01}}, LAT_SUB);
        end
    endtask

    task automatic test_reset_mid_op();
        int           lat;
        logic [127:0] res;
        in_valid = 1'b1;
        op       = 2'b10;
        state_in = {32'h8e4da1bc, 96'h0};
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ((in_ready !== 1'b1) || (out_valid !== 1'b0)) begin
            n_fails++;
            $display("[TB] FAIL midop_reset: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL midop_no_pulse: got %b expected 0", out_valid);
        end
        run_op(2'b10, {32'h8e4da1bc, 96'h0}, '0, lat, res);
        n_checks++;
        if ((res !== {32'hdb135345, 96'h0}) || (lat !== LAT_MIX)) begin
            n_fails++;
            $display("[TB] FAIL midop_recover: got %h lat %0d expected %h lat %0d",
                     res, lat, {32'hdb135345, 96'h0}, LAT_MIX);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset();
        test_inv_mixcolumns();
        test_inv_subbytes();
        test_inv_shiftrows();
        test_inv_round();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/vector_aes_dec_unit.md
# vector_aes_dec_unit

Multicycle AES-128 inverse-cipher functional unit for the vector datapath, complementing the single-cycle encryption ops of the vector ALU. It implements InvShiftRows, InvSubBytes and InvMixColumns, plus a fused equivalent-order inverse round, on a 128-bit state. Inverse S-box and GF(2^8) logic are time-multiplexed over several cycles under a valid/ready handshake. The vector execute stage issues into it and stalls on `in_ready`.

## Interface
- `WIDTH`, 128, state/key width; only 128 is supported.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: unit idle, can accept.
- `op` input 2: 00 INV_SHIFTROWS, 01 INV_SUBBYTES, 10 INV_MIXCOLUMNS, 11 INV_ROUND.
- `state_in` input WIDTH: AES state.
- `rkey_in` input WIDTH: round key; used only by INV_ROUND.
- `out_valid` output 1: `result` valid.
- `out_ready` input 1: consumer accepts result.
- `result` output WIDTH: transformed state.

## Operation
- Byte order follows FIPS-197: byte k = bits [127-8k -: 8]; state[r][c] = byte r+4c, column-major.
- Accept occurs when `in_valid && in_ready` at a rising edge. `op`, `state_in` and `rkey_in` are captured on that edge; `rkey_in` is latched internally.
- FSM states:
  - IDLE: `in_ready`=1. On accept, the work register is loaded with InvShiftRows(`state_in`) for ops 00/11, else `state_in` raw. Next state is DONE (00), SUB (01, 11) or MIX (10).
  - SUB: the column counter `col` (2 bits) selects 4 bytes; those bytes pass through the inverse S-box and are written back; `col` increments.
    - After col=3, the next state is DONE for op 01.
    - For op 11, the whole word is XORed with the latched key in the same write, then the next state is MIX.
  - MIX: column `col` is replaced by InvMixColumns (coefficients 0e 0b 0d 09); `col` increments. After col=3 the next state is DONE.
  - DONE: `out_valid`=1 and `result`=work register. The unit returns to IDLE when `out_ready`=1.
- `col` resets to 0 on every state entry.
- `in_ready`=0 in every state except IDLE. An `in_valid` asserted while busy is ignored and not queued.
- `result` holds its value after the handshake until the next DONE. Outside DONE its value is don't-care for consumers.
- Reset mid-operation: the operation is abandoned, no `out_valid` pulse, and the FSM returns to IDLE.

## Timing
- Reset values: FSM IDLE, `in_ready`=1 (from the first cycle after reset), `out_valid`=0, `result`=0, `col`=0.
- Latency is counted from the accept edge to the first cycle with `out_valid` high:
  - INV_SHIFTROWS: 1.
  - INV_SUBBYTES: 5.
  - INV_MIXCOLUMNS: 5.
  - INV_ROUND: 9.
- Back-to-back throughput: the next accept can occur no earlier than 1 cycle after the result handshake, because IDLE is re-entered first.
- `out_ready` low stalls the unit in DONE indefinitely; `result` stays stable.

## Configuration
- `VAES_DEC_FAST_SBOX_EN` defined:
  - 16 inverse S-box instances; SUB completes in one cycle.
  - Latencies become INV_SUBBYTES 2 and INV_ROUND 6.
- Not defined: 4 instances shared across columns, with the latencies above. Functional results are identical in both builds.

## Structure
- `aes_pkg` holds:
  - the `op` enum `vaes_dec_op`;
  - the inverse S-box table constant;
  - the functions `gf_xtime`, `gf_mul` and `inv_mix_column` (32-bit in and out);
  - the FSM state enum.
- Sub-module `aes_inv_sbox`: one byte in, one byte out, combinational table lookup. It is instantiated 4× or 16× depending on the macro.

## Test plan
- INV_MIXCOLUMNS with column 0 = 8e4da1bc and other columns 0 → result column 0 = db135345, others 0, `out_valid` at cycle 5.
- INV_SUBBYTES with `state_in` = {16{8'h63}} → result 0. `state_in` = {16{8'h7c}} → result {16{8'h01}}.
- INV_SHIFTROWS with `state_in` = 000102…0f → result 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03; latency 1.
- INV_ROUND with `state_in` = {16{8'h63}}:
  - `rkey_in`=0 → result 0;
  - `rkey_in` = {16{8'h01}} → result {16{8'h01}};
  - latency 9, or 6 with the macro.
- Backpressure: `out_ready` held low 10 cycles → `out_valid` and `result` stable, `in_ready`=0, and a concurrent `in_valid` is dropped.
- Assert `rst` during MIX → the next cycle shows IDLE, `out_valid`=0, `in_ready`=1; a new request then completes normally.
